// File: rtl/ppu_reg_file.sv
// ppu_reg_file: CPU-visible PPU registers $2000-$2007, VRAM/OAM access ports.
// Optional PPU_REG_READ_BUFFER_EN: $2007 reads go through a delayed read buffer.
module ppu_reg_file #(
   parameter int VADDR_W    = 14,
   parameter int VINC_LARGE = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs,
   input  logic               WE,
   input  logic [15:0]        cpu_addr_in,
   input  logic [7:0]         cpu_data_in,
   output logic [7:0]         cpu_data_out,
   output logic [VADDR_W-1:0] ppu_addr_out,
   output logic [7:0]         ppu_data_out,
   output logic               ppu_we,
   output logic               ppu_re,
   input  logic [7:0]         ppu_data_in,
   output logic [7:0]         OAM_addr_out,
   output logic [7:0]         OAM_data_out,
   output logic               OAM_we,
   input  logic [7:0]         OAM_data_in,
   input  logic               vblank_set,
   input  logic               vblank_clr,
   input  logic               spr0_set,
   input  logic               ovf_set,
   output logic [7:0]         ctrl_out,
   output logic [7:0]         mask_out,
   output logic [7:0]         scroll_x,
   output logic [7:0]         scroll_y,
   output logic               nmi
);

   logic               rd;
   logic               wr;
   logic [7:0]         hit;
   logic               vbl;
   logic               spr0;
   logic               ovf;
   logic               w;
   logic [VADDR_W-1:0] t;
   logic [VADDR_W-1:0] v;
   logic [VADDR_W-1:0] v_inc;
   logic               oam_we_q;
   logic               pwe_q;
   logic               pre_q;
   logic               cap_q;
   logic [7:0]         status;
   logic               unused_addr;

   assign rd          = cs & ~WE;
   assign wr          = cs & WE;
   assign hit         = 8'(1) << cpu_addr_in[2:0];
   assign unused_addr = ^cpu_addr_in[15:3];
   assign status      = {vbl, spr0, ovf, cpu_data_out[4:0]};
   assign v_inc       = ctrl_out[2] ? VADDR_W'(VINC_LARGE) : VADDR_W'(1);

   assign ppu_addr_out = v;
   assign ppu_we       = pwe_q & ~reset;
   assign ppu_re       = pre_q & ~reset;
   assign OAM_we       = oam_we_q & ~reset;
   assign nmi          = vbl & ctrl_out[7] & ~reset;

   // Control, mask, scroll and the shared first/second-write toggle
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_out <= 8'h00;
         mask_out <= 8'h00;
         scroll_x <= 8'h00;
         scroll_y <= 8'h00;
         t        <= '0;
         w        <= 1'b0;
      end else begin
         if (wr && hit[0])
            ctrl_out <= cpu_data_in;
         if (wr && hit[1])
            mask_out <= cpu_data_in;
         if (wr && hit[5]) begin
            if (!w)
               scroll_x <= cpu_data_in;
            else
               scroll_y <= cpu_data_in;
         end
         if (wr && hit[6]) begin
            if (!w)
               t[VADDR_W-1:8] <= cpu_data_in[VADDR_W-9:0];
            else
               t[7:0] <= cpu_data_in;
         end
         if (rd && hit[2])
            w <= 1'b0;
         else if (wr && (hit[5] || hit[6]))
            w <= ~w;
      end
   end

   // Status flags: any clear this cycle wins over a set
   always_ff @(posedge clk) begin
      if (reset) begin
         vbl  <= 1'b0;
         spr0 <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (vblank_clr || (rd && hit[2]))
            vbl <= 1'b0;
         else if (vblank_set)
            vbl <= 1'b1;
         if (vblank_clr)
            spr0 <= 1'b0;
         else if (spr0_set)
            spr0 <= 1'b1;
         if (vblank_clr)
            ovf <= 1'b0;
         else if (ovf_set)
            ovf <= 1'b1;
      end
   end

   // OAM port: write strobe one cycle after $2004, address bumps after it
   always_ff @(posedge clk) begin
      if (reset) begin
         oam_we_q     <= 1'b0;
         OAM_data_out <= 8'h00;
         OAM_addr_out <= 8'h00;
      end else begin
         oam_we_q <= wr & hit[4];
         if (wr && hit[4])
            OAM_data_out <= cpu_data_in;
         if (wr && hit[3])
            OAM_addr_out <= cpu_data_in;
         else if (oam_we_q)
            OAM_addr_out <= OAM_addr_out + 8'd1;
      end
   end

   // VRAM port: strobe at old v, advance v on the strobe cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         pwe_q        <= 1'b0;
         pre_q        <= 1'b0;
         cap_q        <= 1'b0;
         ppu_data_out <= 8'h00;
         v            <= '0;
      end else begin
         pwe_q <= wr & hit[7];
         pre_q <= rd & hit[7];
         cap_q <= pre_q;
         if (wr && hit[7])
            ppu_data_out <= cpu_data_in;
         if (wr && hit[6] && w)
            v <= {t[VADDR_W-1:8], cpu_data_in};
         else if (pwe_q || pre_q)
            v <= v + v_inc;
      end
   end

`ifdef PPU_REG_READ_BUFFER_EN
   logic [7:0] rbuf;

   // Read buffer takes the VRAM byte when it arrives
   always_ff @(posedge clk) begin
      if (reset)
         rbuf <= 8'h00;
      else if (cap_q)
         rbuf <= ppu_data_in;
   end

   // CPU read data; a $2007 read hands back the previous buffer,
   // forwarding a byte that lands in the same cycle
   always_ff @(posedge clk) begin
      if (reset)
         cpu_data_out <= 8'h00;
      else if (rd && hit[2])
         cpu_data_out <= status;
      else if (rd && hit[4])
         cpu_data_out <= OAM_data_in;
      else if (pre_q)
         cpu_data_out <= cap_q ? ppu_data_in : rbuf;
   end
`else
   // CPU read data; a $2007 read returns the VRAM byte when it arrives
   always_ff @(posedge clk) begin
      if (reset)
         cpu_data_out <= 8'h00;
      else if (rd && hit[2])
         cpu_data_out <= status;
      else if (rd && hit[4])
         cpu_data_out <= OAM_data_in;
      else if (cap_q)
         cpu_data_out <= ppu_data_in;
   end
`endif

endmodule
